// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU shift datapath.
//   - XLEN / SHAMT_W : datapath width and shift-amount width
//   - shift_op_e     : 2-bit shift opcode (10 is the illegal encoding)
package alu_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_ILL = 2'b10,
    OP_SRA = 2'b11
  } shift_op_e;

endpackage : alu_pkg

// File: rtl/alu_shift_core.sv
// alu_shift_core: combinational shift unit (SLL/SRL/SRA).
//   op    in  2        shift opcode (see shift_op_e)
//   rs1   in  XLEN     operand to shift
//   shamt in  SHAMT_W  shift amount
//   rd    out XLEN     result; 0 for the illegal opcode
//   err   out 1        high for the illegal opcode
module alu_shift_core
  import alu_pkg::*;
(
  input  logic [1:0]         op,
  input  logic [XLEN-1:0]    rs1,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [XLEN-1:0]    rd,
  output logic               err
);

  logic [XLEN-1:0] sll_res;

  alu_sll u_sll (
    .a     (rs1),
    .shamt (shamt),
    .y     (sll_res)
  );

  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves it unassigned, which would infer a latch.
    rd  = '0;
    err = 1'b0;
    case (shift_op_e'(op))
      OP_SLL:  rd = sll_res;
      OP_SRL:  rd = rs1 >> shamt;
      // Arithmetic shift: sign bit rs1[XLEN-1] is replicated from the MSB.
      OP_SRA:  rd = $unsigned($signed(rs1) >>> shamt);
      default: err = 1'b1;
    endcase
  end

endmodule : alu_shift_core

// File: rtl/alu_sll.sv
// alu_sll: combinational logical left shift, zeros enter at the LSB.
//   a     in  XLEN     operand
//   shamt in  SHAMT_W  shift amount
//   y     out XLEN     a << shamt
module alu_sll
  import alu_pkg::*;
(
  input  logic [XLEN-1:0]    a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [XLEN-1:0]    y
);

  assign y = a << shamt;

endmodule : alu_sll

// File: rtl/alu_shift_arbiter.sv
// alu_shift_arbiter: shares one shift unit between two requesters.
// Round-robin arbitration, one-entry output register with backpressure,
// one cycle latency, full throughput while rsp_ready is high.
//   clk, rst_n                     clock, synchronous active-low reset
//   reqN_valid/ready               request handshake, port N (0/1)
//   reqN_op/rs1/rs2/tag            request payload (only rs2[4:0] used)
//   rsp_valid/ready                response handshake
//   rsp_rd/tag/port/err            registered response payload
module alu_shift_arbiter
  import alu_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [XLEN-1:0]  req0_rs1,
  input  logic [XLEN-1:0]  req0_rs2,
  input  logic [TAG_W-1:0] req0_tag,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [XLEN-1:0]  req1_rs1,
  input  logic [XLEN-1:0]  req1_rs2,
  input  logic [TAG_W-1:0] req1_tag,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_rd,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_port,
  output logic             rsp_err
);

  logic             rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]  rsp_rd_q,    rsp_rd_d;
  logic [TAG_W-1:0] rsp_tag_q,   rsp_tag_d;
  logic             rsp_port_q,  rsp_port_d;
  logic             rsp_err_q,   rsp_err_d;
  logic             last_grant_q, last_grant_d;

  logic             can_accept;
  logic             grant;
  logic             accept;
  logic [1:0]       sel_op;
  logic [XLEN-1:0]  sel_rs1;
  logic [XLEN-1:0]  sel_rs2;
  logic [TAG_W-1:0] sel_tag;
  logic [XLEN-1:0]  core_rd;
  logic             core_err;
  logic             unused_rs2_hi;

  // The register can take a new result when empty or when it drains this cycle.
  assign can_accept = !rsp_valid_q || rsp_ready;

  // Single valid port wins outright; on contention the port not granted last
  // time wins. With no valid port the grant value is irrelevant.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = !last_grant_q;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready = can_accept && (grant == 1'b0);
  assign req1_ready = can_accept && (grant == 1'b1);
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign sel_op  = grant ? req1_op  : req0_op;
  assign sel_rs1 = grant ? req1_rs1 : req0_rs1;
  assign sel_rs2 = grant ? req1_rs2 : req0_rs2;
  assign sel_tag = grant ? req1_tag : req0_tag;

  // Upper shift-amount bits are architecturally ignored.
  assign unused_rs2_hi = ^sel_rs2[XLEN-1:SHAMT_W];

  alu_shift_core u_core (
    .op    (sel_op),
    .rs1   (sel_rs1),
    .shamt (sel_rs2[SHAMT_W-1:0]),
    .rd    (core_rd),
    .err   (core_err)
  );

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_rd_d     = rsp_rd_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_port_d   = rsp_port_q;
    rsp_err_d    = rsp_err_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      // Covers both the empty case and a same-cycle drain + reload.
      rsp_valid_d  = 1'b1;
      rsp_rd_d     = core_rd;
      rsp_tag_d    = sel_tag;
      rsp_port_d   = grant;
      rsp_err_d    = core_err;
      last_grant_d = grant;
    end else if (rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_rd_q     <= '0;
      rsp_tag_q    <= '0;
      rsp_port_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      // Starting at 1 makes port 0 win the first contention.
      last_grant_q <= 1'b1;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_rd_q     <= rsp_rd_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_port_q   <= rsp_port_d;
      rsp_err_q    <= rsp_err_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rd    = rsp_rd_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_port  = rsp_port_q;
  assign rsp_err   = rsp_err_q;

endmodule : alu_shift_arbiter
